// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - pattern select/pause inputs and LED/strobe outputs of led_pattern_gen
// speed is present only when LED_PATTERN_SPEED_SEL_EN is defined.
interface led_pattern_gen_if #(
    parameter int N_LED = 8
);
    logic [1:0]       mode;
    logic             pause;
    logic [N_LED-1:0] led;
    logic             step;
    logic             wrap;
`ifdef LED_PATTERN_SPEED_SEL_EN
    logic [1:0]       speed;

    modport master (output mode, pause, speed, input led, step, wrap);
    modport slave  (input mode, pause, speed, output led, step, wrap);
`else
    modport master (output mode, pause, input led, step, wrap);
    modport slave  (input mode, pause, output led, step, wrap);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - parametrised LED pattern sequencer with clock-enable prescaler
// Optional LED_PATTERN_SPEED_SEL_EN: io.speed divides the step period by 2^speed.
module led_pattern_gen #(
    parameter int N_LED   = 8,
    parameter int CLK_HZ  = 50000000,
    parameter int STEP_HZ = 1
) (
    input  logic             clk,
    input  logic             rs,
    led_pattern_gen_if.slave io
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [N_LED-1:0] ONES = '1;

    typedef enum logic {FILL, DRAIN} phase_t;
    typedef enum logic {UP, DOWN} dir_t;

    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d, tc;
    phase_t           phase_q, phase_d, nxt_phase;
    dir_t             dir_q, dir_d, nxt_dir;
    logic [N_LED-1:0] led_q, led_d, nxt;
    logic             step_q, step_d, wrap_q, wrap_d;
    logic             tick, legal;

    function automatic logic [N_LED-1:0] init_of(input logic [1:0] m);
        return m[1] ? N_LED'(1) : '0;
    endfunction

    // true for values of the form 0..01..1 (including 0 and all-ones)
    function automatic logic low_mask(input logic [N_LED-1:0] v);
        return (v & (v + N_LED'(1))) == '0;
    endfunction

`ifdef LED_PATTERN_SPEED_SEL_EN
    logic [31:0] div_s;
    always_comb begin
        div_s = 32'(DIV) >> io.speed;
        tc    = (div_s > 32'd1) ? CW'(div_s - 32'd1) : '0;
    end
    assign tick = !io.pause && (cnt_q >= tc);
`else
    assign tc   = CW'(DIV - 1);
    assign tick = !io.pause && (cnt_q == tc);
`endif

    always_comb begin
        nxt       = led_q;
        nxt_phase = phase_q;
        nxt_dir   = dir_q;
        legal     = 1'b1;
        case (mode_q)
            2'd0: begin
                legal = low_mask(led_q);
                nxt   = (led_q == ONES) ? '0 : {led_q[N_LED-2:0], 1'b1};
            end
            2'd1: begin
                if (phase_q == FILL) begin
                    legal = low_mask(led_q) && (led_q != ONES);
                    nxt   = {led_q[N_LED-2:0], 1'b1};
                    if (nxt == ONES) nxt_phase = DRAIN;
                end else begin
                    legal = low_mask(~led_q) && (led_q != '0);
                    nxt   = {led_q[N_LED-2:0], 1'b0};
                    if (nxt == '0) nxt_phase = FILL;
                end
            end
            2'd2: begin
                legal = $onehot(led_q);
                nxt   = {led_q[N_LED-2:0], led_q[N_LED-1]};
            end
            default: begin
                legal = $onehot(led_q) && !(dir_q == UP && led_q[N_LED-1])
                        && !(dir_q == DOWN && led_q[0]);
                if (dir_q == UP) begin
                    nxt = led_q << 1;
                    if (nxt[N_LED-1]) nxt_dir = DOWN;
                end else begin
                    nxt = led_q >> 1;
                    if (nxt[0]) nxt_dir = UP;
                end
            end
        endcase
        // corrupted pattern state recovers to the mode's start value
        if (!legal) begin
            nxt       = init_of(mode_q);
            nxt_phase = FILL;
            nxt_dir   = UP;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        led_d   = led_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (io.mode != mode_q) begin
            mode_d  = io.mode;
            cnt_d   = '0;
            phase_d = FILL;
            dir_d   = UP;
            led_d   = init_of(io.mode);
        end else if (tick) begin
            cnt_d   = '0;
            led_d   = nxt;
            phase_d = nxt_phase;
            dir_d   = nxt_dir;
            step_d  = 1'b1;
            wrap_d  = (nxt == init_of(mode_q));
        end else if (!io.pause) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            mode_q  <= 2'd0;
            cnt_q   <= '0;
            phase_q <= FILL;
            dir_q   <= UP;
            led_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign io.led  = led_q;
    assign io.step = step_q;
    assign io.wrap = wrap_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen (N_LED=8, DIV=4)
module tb_led_pattern_gen;
    localparam int N   = 8;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rs;
    always #5 clk = ~clk;

    led_pattern_gen_if #(.N_LED(N)) bus ();

    led_pattern_gen #(.N_LED(N), .CLK_HZ(8), .STEP_HZ(2)) dut (
        .clk(clk),
        .rs (rs),
        .io (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        int         ticks;
        logic [7:0] led;
        logic       step;
        logic       wrap;
    } vec_t;

    vec_t vecs[18];

    // reference model: pattern as position within a per-mode sequence
    int   m_mq, m_pos, m_cnt;
    logic m_step, m_wrap;

    function automatic int seq_len(input int m);
        case (m)
            0:       return N + 1;
            1:       return 2 * N;
            2:       return N;
            default: return 2 * N - 2;
        endcase
    endfunction

    function automatic logic [7:0] seq_val(input int m, input int p);
        int ones = (1 << N) - 1;
        case (m)
            0:       return 8'((1 << p) - 1);
            1:       return (p <= N) ? 8'((1 << p) - 1) : 8'((ones << (p - N)) & ones);
            2:       return 8'(1 << p);
            default: return (p < N) ? 8'(1 << p) : 8'(1 << (2 * N - 2 - p));
        endcase
    endfunction

    task automatic model_edge(input logic r, input int mode, input logic pz);
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (r) begin
            m_mq = 0; m_pos = 0; m_cnt = 0;
        end else if (mode != m_mq) begin
            m_mq = mode; m_pos = 0; m_cnt = 0;
        end else if (!pz) begin
            if (m_cnt == DIV - 1) begin
                m_cnt  = 0;
                m_pos  = (m_pos + 1) % seq_len(m_mq);
                m_step = 1'b1;
                m_wrap = (m_pos == 0);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // leaves the DUT just after the edge where cnt was cleared for mode m
    task automatic reset_to(input logic [1:0] m);
        rs        = 1'b1;
        bus.mode  = m;
        bus.pause = 1'b0;
        cyc();
        rs = 1'b0;
        if (m != 2'd0) cyc();
    endtask

    initial begin
        rs        = 1'b1;
        bus.mode  = 2'd0;
        bus.pause = 1'b0;
`ifdef LED_PATTERN_SPEED_SEL_EN
        bus.speed = 2'd0;
`endif
        vecs[0]  = '{2'd0, 0,  8'h00, 1'b0, 1'b0};
        vecs[1]  = '{2'd0, 1,  8'h01, 1'b1, 1'b0};
        vecs[2]  = '{2'd0, 3,  8'h07, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 8,  8'hFF, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 9,  8'h00, 1'b1, 1'b1};
        vecs[5]  = '{2'd1, 0,  8'h00, 1'b0, 1'b0};
        vecs[6]  = '{2'd1, 8,  8'hFF, 1'b1, 1'b0};
        vecs[7]  = '{2'd1, 9,  8'hFE, 1'b1, 1'b0};
        vecs[8]  = '{2'd1, 15, 8'h80, 1'b1, 1'b0};
        vecs[9]  = '{2'd1, 16, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{2'd1, 17, 8'h01, 1'b1, 1'b0};
        vecs[11] = '{2'd2, 0,  8'h01, 1'b0, 1'b0};
        vecs[12] = '{2'd2, 7,  8'h80, 1'b1, 1'b0};
        vecs[13] = '{2'd2, 8,  8'h01, 1'b1, 1'b1};
        vecs[14] = '{2'd3, 0,  8'h01, 1'b0, 1'b0};
        vecs[15] = '{2'd3, 7,  8'h80, 1'b1, 1'b0};
        vecs[16] = '{2'd3, 8,  8'h40, 1'b1, 1'b0};
        vecs[17] = '{2'd3, 14, 8'h01, 1'b1, 1'b1};

        for (int v = 0; v < 18; v++) begin
            reset_to(vecs[v].mode);
            cycles(vecs[v].ticks * DIV);
            chk($sformatf("vec%0d_led", v), 32'(bus.led), 32'(vecs[v].led));
            chk($sformatf("vec%0d_step", v), 32'(bus.step), 32'(vecs[v].step));
            chk($sformatf("vec%0d_wrap", v), 32'(bus.wrap), 32'(vecs[v].wrap));
        end

        // led is frozen while paused and the pending count resumes afterwards
        reset_to(2'd3);
        cycles(6);
        chk("pause_pre_led", 32'(bus.led), 32'h02);
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("pause_led", 32'(bus.led), 32'h02);
            chk("pause_step", 32'(bus.step), 32'h0);
        end
        bus.pause = 1'b0;
        cyc();
        chk("resume1_led", 32'(bus.led), 32'h02);
        cyc();
        chk("resume2_led", 32'(bus.led), 32'h04);
        chk("resume2_step", 32'(bus.step), 32'h1);

        // restart wins over a tick in the same cycle
        reset_to(2'd2);
        cycles(3);
        bus.mode = 2'd0;
        cyc();
        chk("restart_led", 32'(bus.led), 32'h00);
        chk("restart_step", 32'(bus.step), 32'h0);
        chk("restart_wrap", 32'(bus.wrap), 32'h0);
        cycles(3);
        chk("restart_hold_led", 32'(bus.led), 32'h00);
        cyc();
        chk("restart_first_led", 32'(bus.led), 32'h01);
        chk("restart_first_step", 32'(bus.step), 32'h1);

        // reset mid-pattern, then restart back into mode 3
        reset_to(2'd3);
        cycles(8);
        chk("midrst_pre_led", 32'(bus.led), 32'h04);
        rs = 1'b1;
        cyc();
        rs = 1'b0;
        chk("midrst_led", 32'(bus.led), 32'h00);
        chk("midrst_step", 32'(bus.step), 32'h0);
        cyc();
        chk("midrst_restart_led", 32'(bus.led), 32'h01);
        chk("midrst_restart_step", 32'(bus.step), 32'h0);

        // randomized run against the sequence-position model
        for (int i = 0; i < 3000; i++) begin
            rs = (i == 0) || ($urandom_range(99) < 2);
            if ($urandom_range(99) < 3) bus.mode = 2'($urandom_range(3));
            bus.pause = ($urandom_range(99) < 15);
            model_edge(rs, int'(bus.mode), bus.pause);
            cyc();
            chk("rand_led", 32'(bus.led), 32'(seq_val(m_mq, m_pos)));
            chk("rand_step", 32'(bus.step), 32'(m_step));
            chk("rand_wrap", 32'(bus.wrap), 32'(m_wrap));
        end
        rs = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the single-pattern 8-LED fill sequencer.
- Has an internal clock-enable prescaler, so no derived clock is needed. Runs on the board clock directly.
- Supports any LED count and four selectable patterns, with pause, step and wrap strobes.
- Sits between the board clock/reset and the LED pins; the top level instantiates it in place of the divider + sequencer pair.

Parameters:
- N_LED, 8, number of LEDs (>=2).
- CLK_HZ, 50000000, input clock frequency.
- STEP_HZ, 1, pattern step rate. DIV = CLK_HZ/STEP_HZ, must be >=1.

Ports:
- clk  input  1  board clock, rising edge.
- rs  input  1  synchronous active-high reset.
- mode  input  2  pattern select: 0 fill, 1 fill-drain, 2 running dot, 3 ping-pong.
- pause  input  1  1 = freeze prescaler and pattern.
- led  output  N_LED  LED drive, bit0 = first LED.
- step  output  1  one-cycle pulse coincident with each new led value produced by a tick.
- wrap  output  1  one-cycle pulse when a tick returns led to the mode's start value.

Behaviour:
- Reset (rs=1 at a clk edge, overrides everything, including mid-pattern):
  - led=0, mode_q=0, phase=FILL, dir=UP, cnt=0, step=0, wrap=0.
- Prescaler:
  - cnt width is $clog2(DIV), minimum 1.
  - If pause=0: cnt counts 0..DIV-1 and wraps; tick is internal, 1 when cnt==DIV-1 and pause=0.
  - If pause=1: cnt holds, no tick is produced, led/phase/dir hold.
  - DIV=1 gives a tick every unpaused cycle.
- Restart:
  - Condition: mode != mode_q.
  - Next edge: mode_q<=mode, cnt<=0, phase<=FILL, dir<=UP, led<=INIT(mode), step=0, wrap=0.
  - INIT values: 0 for modes 0/1, 1 for modes 2/3.
  - Restart takes priority over a simultaneous tick (the tick is discarded). Restart applies even while pause=1.
- On tick (no restart), per mode_q:
  - Mode 0, fill: if led==all-ones, led<=0; else led<={led[N-2:0],1}. Period N+1 ticks.
  - Mode 1, fill-drain:
    - FILL: led<={led[N-2:0],1}; if result is all-ones, phase<=DRAIN.
    - DRAIN: led<={led[N-2:0],0}; if result is 0, phase<=FILL.
    - Period 2N ticks.
  - Mode 2, dot: led<={led[N-2:0],led[N-1]} (rotate left). Period N.
  - Mode 3, ping-pong:
    - UP: led<<1; if result bit N-1 is set, dir<=DOWN.
    - DOWN: led>>1; if result bit0 is set, dir<=UP.
    - Period 2N-2.
  - Any mode_q: if led is not a legal state for the mode (e.g. multiple bits set in modes 2/3), led<=INIT(mode_q) on the tick.
- Strobe timing:
  - step and wrap are registered and asserted in the same cycle the updated led is first visible, i.e. 1 cycle after the tick cycle.
  - wrap=1 iff a tick produced led==INIT(mode_q). Never asserted by reset or restart.
- Latency: led changes exactly DIV unpaused cycles after the previous step (or after the reset/restart edge).

Optional Feature:
- Macro: LED_PATTERN_SPEED_SEL_EN.
- When defined:
  - Adds input speed[1:0].
  - Terminal count becomes TC = max(DIV>>speed, 1) - 1, and tick fires when cnt>=TC (cnt<=0 on tick).
  - A speed change takes effect immediately via this comparison; no restart.
- When undefined: the port is absent and TC = DIV-1 is fixed.

Test Plan (CLK_HZ=8, STEP_HZ=2 -> DIV=4, N_LED=8):
- Reset then mode=0, pause=0:
  - led=00 for 4 cycles, then 01,03,07,...,FF,00, one value per 4 cycles.
  - step pulses each change; wrap pulses only with 00.
- mode=1 from reset:
  - After the restart edge: 01,03,...,FF,FE,FC,...,80,00.
  - wrap on 00 after exactly 16 ticks, then the sequence repeats from 01.
- mode=2: led=01 on the restart edge, then 02,04,...,80,01; wrap with 01 after 8 ticks.
- mode=3:
  - 01 on restart, then 02..80,40..01.
  - dir flips at 80 and 01; wrap after 14 ticks.
  - Hold pause=1 for 10 cycles mid-pattern: led and cnt frozen, no step. Resume completes the remaining count.
- Switch mode 2->0 in the same cycle as a tick: next edge led=00, cnt=0, no step/wrap. First step (01) arrives 4 cycles later.
- Assert rs for 1 cycle mid-sequence in mode 3 while mode input stays 3:
  - Next edge: led=00, step=0.
  - Following edge: restart gives led=01.
